// File: rtl/xaui_tx_idle_gen_pkg.sv
// Shared code-group constants, column classification types and helpers for the
// XAUI transmit idle generator.
package xaui_tx_idle_gen_pkg;

  localparam logic [7:0] CODE_I = 8'h07;
  localparam logic [7:0] CODE_T = 8'hFD;
  localparam logic [7:0] CODE_A = 8'h7C;  // K28.3
  localparam logic [7:0] CODE_K = 8'hBC;  // K28.5
  localparam logic [7:0] CODE_R = 8'h1C;  // K28.0

  typedef enum logic [1:0] {
    KIND_IDLE = 2'd0,
    KIND_TERM = 2'd1,
    KIND_DATA = 2'd2
  } col_kind_e;

  typedef enum logic [1:0] {
    CLS_A = 2'd0,
    CLS_K = 2'd1,
    CLS_R = 2'd2
  } col_cls_e;

  // One classified column held in stage 1; fill marks the /I/ lanes after /T/.
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  c;
    col_kind_e   kind;
    col_cls_e    cls;
    logic [3:0]  fill;
  } stage_t;

  function automatic logic [7:0] cls_code(input col_cls_e cls);
    case (cls)
      CLS_A:   return CODE_A;
      CLS_R:   return CODE_R;
      default: return CODE_K;
    endcase
  endfunction

endpackage

// File: rtl/xaui_tx_prbs7.sv
// PRBS7 (x^7 + x^6 + 1) randomizer with step enable, seeded to 7'h7F on reset.
module xaui_tx_prbs7 (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_en,
  output logic [6:0] state
);

  logic [6:0] state_q;
  logic [6:0] state_d;

  always_comb begin
    state_d = state_q;
    if (step_en) state_d = {state_q[5:0], state_q[6] ^ state_q[5]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= 7'h7F;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/xaui_tx_idle_gen.sv
// XGMII-to-XAUI transmit idle generator: replaces idle columns with ||A||/||K||/||R||
// and fills the /I/ lanes after /T/. Define XAUI_TX_IDLE_RAND_EN for PRBS7 K/R selection.
module xaui_tx_idle_gen
  import xaui_tx_idle_gen_pkg::*;
#(
  parameter int A_MIN = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] xgmii_txd,
  input  logic [3:0]  xgmii_txc,
  output logic [31:0] txd,
  output logic [3:0]  txc,
  output logic        a_sent
);

  localparam stage_t S1_RESET = '{d: {4{CODE_I}}, c: 4'hF, kind: KIND_IDLE,
                                  cls: CLS_K, fill: 4'h0};

  logic        rand_bit;
  logic [4:0]  a_reload;

`ifdef XAUI_TX_IDLE_RAND_EN
  logic [6:0] prbs;
  logic       unused_prbs;

  xaui_tx_prbs7 u_prbs (
    .clk     (clk),
    .reset   (reset),
    .step_en (1'b1),
    .state   (prbs)
  );

  assign rand_bit    = prbs[0];
  assign a_reload    = 5'(A_MIN - 1) + {1'b0, prbs[6:3]};
  assign unused_prbs = ^prbs[2:1];
`else
  assign rand_bit = 1'b1;
  assign a_reload = 5'(A_MIN - 1);
`endif

  stage_t      s1_q, s1_d;
  logic [4:0]  a_cnt_q, a_cnt_d;
  logic [31:0] txd_q, txd_d;
  logic [3:0]  txc_q, txc_d;
  logic        a_sent_q, a_sent_d;

  logic [3:0]  lane_i, lane_t, fill;
  logic        found_t, term_ok, all_idle;
  col_kind_e   in_kind;
  col_cls_e    in_cls;

  always_comb begin
    lane_i = '0;
    lane_t = '0;
    for (int n = 0; n < 4; n++) begin
      lane_i[n] = xgmii_txc[n] && (xgmii_txd[8*n +: 8] == CODE_I);
      lane_t[n] = xgmii_txc[n] && (xgmii_txd[8*n +: 8] == CODE_T);
    end
  end

  // Stage 1: classify the incoming column, pick its idle class and advance a_cnt.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    found_t  = 1'b0;
    term_ok  = 1'b1;
    all_idle = &lane_i;
    fill     = '0;
    for (int n = 0; n < 4; n++) begin
      if (found_t) begin
        fill[n] = 1'b1;
        if (!lane_i[n]) term_ok = 1'b0;
      end else if (lane_t[n]) begin
        found_t = 1'b1;
      end
    end

    if (all_idle)                in_kind = KIND_IDLE;
    else if (found_t && term_ok) in_kind = KIND_TERM;
    else                         in_kind = KIND_DATA;

    // Non-idle columns carry class K so a /T/ followed by data fills with /K/.
    in_cls  = CLS_K;
    a_cnt_d = a_cnt_q;
    if (in_kind == KIND_IDLE && a_cnt_q == 5'd0) begin
      in_cls  = CLS_A;
      a_cnt_d = a_reload;
    end else begin
      if (in_kind == KIND_IDLE && s1_q.kind != KIND_TERM)
        in_cls = rand_bit ? CLS_K : CLS_R;
      if (a_cnt_q != 5'd0) a_cnt_d = a_cnt_q - 5'd1;
    end

    s1_d      = '{d: xgmii_txd, c: xgmii_txc, kind: in_kind, cls: in_cls,
                  fill: (in_kind == KIND_TERM) ? fill : 4'h0};
  end

  // Stage 2: substitute idle columns and /T/ fill lanes; fill follows the column behind.
  always_comb begin
    txd_d    = s1_q.d;
    txc_d    = s1_q.c;
    a_sent_d = 1'b0;
    case (s1_q.kind)
      KIND_IDLE: begin
        txd_d    = {4{cls_code(s1_q.cls)}};
        txc_d    = 4'hF;
        a_sent_d = (s1_q.cls == CLS_A);
      end
      KIND_TERM: begin
        for (int n = 0; n < 4; n++) begin
          if (s1_q.fill[n]) begin
            txd_d[8*n +: 8] = cls_code(in_cls);
            txc_d[n]        = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= S1_RESET;
      a_cnt_q  <= 5'd0;
      txd_q    <= {4{CODE_K}};
      txc_q    <= 4'hF;
      a_sent_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values.
      s1_q     <= s1_d;
      a_cnt_q  <= a_cnt_d;
      txd_q    <= txd_d;
      txc_q    <= txc_d;
      a_sent_q <= a_sent_d;
    end
  end

  assign txd    = txd_q;
  assign txc    = txc_q;
  assign a_sent = a_sent_q;

endmodule
